// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the pointer-width helper used by sync_fifo.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    // One extra pointer bit tells full apart from empty when the addresses match.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array with one synchronous write port and one registered read port.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // The array itself carries no reset so it can map onto plain storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extended pointers, threshold flags, flush and sticky error flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rinc,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ptr_width(ADDR_WIDTH);

    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_TH);

    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull_th
        $error("sync_fifo: AFULL_TH must lie in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty_th
        $error("sync_fifo: AEMPTY_TH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0] wptr_reg, wptr_next;
    logic [PW-1:0] rptr_reg, rptr_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          wr_accept;
    logic          rd_accept;

    // Status is decoded from registered pointers only, so it follows reset asynchronously.
    assign rempty       = (wptr_reg == rptr_reg);
    assign wfull        = (wptr_reg == {~rptr_reg[PW-1], rptr_reg[PW-2:0]});
    assign fill_level   = wptr_reg - rptr_reg;
    assign almost_full  = (fill_level >= AFULL_LVL);
    assign almost_empty = (fill_level <= AEMPTY_LVL);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign wr_accept = winc & ~wfull & ~flush;
    assign rd_accept = rinc & ~rempty & ~flush;

    always_comb begin
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            if (wr_accept) begin
                wptr_next = wptr_reg + PW'(1);
            end
            if (rd_accept) begin
                rptr_next = rptr_reg + PW'(1);
            end
        end

        // A fresh error event in the clearing cycle must not be lost.
        if (clr_err) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (winc && wfull && !flush) begin
            overflow_next = 1'b1;
        end
        if (rinc && rempty && !flush) begin
            underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_addr (wptr_reg[ADDR_WIDTH-1:0]),
        .wr_data (wdata),
        .rd_en   (rd_accept),
        .rd_addr (rptr_reg[ADDR_WIDTH-1:0]),
        .rd_data (rdata)
    );

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, with DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost-full threshold in entries, legal range 1..DEPTH.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold in entries, legal range 0..DEPTH-1.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk (in, 1) is the sole clock; rst_n (in, 1) is the asynchronous active-low reset.
REQ-006 SHALL have these ports:
- winc, in, 1: write request.
- wdata, in, DATA_WIDTH: write data.
- rinc, in, 1: read request.
- flush, in, 1: synchronous empty command.
- clr_err, in, 1: clears the sticky error flags.
- rdata, out, DATA_WIDTH: read data.
- wfull, out, 1: FIFO full.
- rempty, out, 1: FIFO empty.
- almost_full, out, 1: threshold flag.
- almost_empty, out, 1: threshold flag.
- fill_level, out, ADDR_WIDTH+1: current occupancy.
- overflow, out, 1: sticky write-while-full.
- underflow, out, 1: sticky read-while-empty.

Function
REQ-007 SHALL accept a write on a rising clk edge iff winc=1, wfull=0 and flush=0, storing wdata at the write pointer.
REQ-008 SHALL accept a read on a rising clk edge iff rinc=1, rempty=0 and flush=0, loading rdata from the read pointer at that edge (1-cycle latency); rdata SHALL hold its value otherwise.
REQ-009 SHALL use write and read pointers of ADDR_WIDTH+1 bits that wrap from 2*DEPTH-1 to 0; the low ADDR_WIDTH bits address memory.
REQ-010 SHALL assert wfull when the pointers differ only in the MSB, and rempty when the pointers are equal; both SHALL be registered or decoded from registered pointers only.
REQ-011 SHALL keep fill_level = wptr - rptr modulo 2*DEPTH, range 0..DEPTH.
REQ-012 SHALL drive almost_full = (fill_level >= AFULL_TH) and almost_empty = (fill_level <= AEMPTY_TH).
REQ-013 SHALL accept both operations on simultaneous winc and rinc when 0 < fill_level < DEPTH; fill_level is then unchanged.
REQ-014 SHALL, on simultaneous winc and rinc when full, accept only the read and reject the write.
REQ-015 SHALL, on simultaneous winc and rinc when empty, accept only the write; the new word is not readable before the next cycle.
REQ-016 SHALL set overflow on winc=1 while wfull=1, and set underflow on rinc=1 while rempty=1 (flush=0); both SHALL hold until clr_err=1 or reset; a set event in the same cycle as clr_err SHALL win.
REQ-017 SHALL, on flush=1, zero both pointers at the next edge, ignore winc and rinc in that cycle, leave rdata and memory contents unchanged, and not affect the error flags.
REQ-018 SHALL never alter memory contents or pointers on a rejected request.

Reset
REQ-019 SHALL, while rst_n=0, asynchronously force pointers=0, fill_level=0, rempty=1, wfull=0, almost_empty=1, almost_full=0, overflow=0, underflow=0 and rdata=0.
REQ-020 SHALL not reset the memory array, and SHALL resume normal operation on the first clk edge after rst_n deasserts, including when reset hits mid-transfer.

Structure
REQ-021 SHALL take default DATA_WIDTH/ADDR_WIDTH constants and a pointer-width helper function from shared package fifo_pkg.
REQ-022 SHALL place storage in sub-module sync_fifo_mem: a DEPTH x DATA_WIDTH register array with one synchronous write port and one registered read port.
REQ-023 SHALL reject illegal AFULL_TH/AEMPTY_TH values by elaboration-time assertion.

Verification
REQ-024 SHALL cover write fill: DEPTH=8, write 0x01..0x08 -> wfull=1, fill_level=8, almost_full from level 6, and a 9th write sets overflow with data unchanged.
REQ-025 SHALL cover drain: read 8 words -> rdata 0x01..0x08 each one cycle after its rinc, rempty=1 after the 8th, and a 9th read sets underflow.
REQ-026 SHALL cover wrap: 20 interleaved single writes and reads -> correct order across pointer wrap, fill_level never above 1.
REQ-027 SHALL cover simultaneous access: winc+rinc at level 4 -> level stays 4; at full -> level 7, overflow=1; at empty -> level 1, underflow=1.
REQ-028 SHALL cover flush: flush at level 5 with winc=1 -> level 0, rempty=1, rdata unchanged; then clr_err -> overflow=0 and underflow=0.
REQ-029 SHALL cover mid-operation reset: rst_n low at level 3 -> all outputs at reset values with no clk edge, and a clean write/read of 0xA5 afterwards.
